// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: access sizes, FSM states,
// default RAM window and the window bound check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [31:0] RAM_ORI_DEF = 32'h0020_0000;
    localparam logic [31:0] RAM_LEN_DEF = 32'h0010_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // 33-bit arithmetic so that an access running past 0xFFFF_FFFF cannot wrap into the window.
    function automatic logic in_window(input logic [31:0] addr, input logic [1:0] size,
                                       input logic [31:0] ori, input logic [31:0] len);
        logic [32:0] last;
        logic [32:0] limit;
        last  = {1'b0, addr} + 33'(size_bytes(size)) - 33'd1;
        limit = {1'b0, ori} + {1'b0, len};
        in_window = (size != SZ_ILL) && (addr >= ori) && (last < limit);
    endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Byte/half extraction with sign or zero extension for loads, and low-lane merge
// of store data into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic sign_b;
    logic sign_h;

    assign sign_b = ~unsigned_i & word_i[7];
    assign sign_h = ~unsigned_i & word_i[15];

    always_comb begin
        load_o  = word_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{sign_b}}, word_i[7:0]};
                merge_o = {word_i[31:8], wdata_i[7:0]};
            end
            SZ_HALF: begin
                load_o  = {{16{sign_h}}, word_i[15:0]};
                merge_o = {word_i[31:16], wdata_i[15:0]};
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port onto a combinational-read RAM; sub-word
// stores are done as read-modify-write of the 32-bit word at the access address.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter logic [31:0] RAM_ORI = RAM_ORI_DEF,
    parameter logic [31:0] RAM_LEN = RAM_LEN_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic        ram_rd_en_o,
    output logic [31:0] ram_rd_addr_o,
    input  logic [31:0] ram_rd_data_i,
    output logic        ram_wr_en_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o
);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [31:0] word_q, word_d;

    logic        accept;
    logic        req_fault;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Ready is gated by reset so nothing can be accepted on a reset edge.
    assign req_ready_o = rst_i & (state_q == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign req_fault   = ~in_window(req_addr_i, req_size_i, RAM_ORI, RAM_LEN);

    lsu_align u_align (
        .size_i     (req_q.size),
        .unsigned_i (req_q.uns),
        .word_i     (word_q),
        .wdata_i    (req_q.wdata),
        .load_o     (load_val),
        .merge_o    (merge_val)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d.we    = req_we_i;
                    req_d.size  = req_size_i;
                    req_d.uns   = req_unsigned_i;
                    req_d.err   = req_fault;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (!req_we_i) begin
                        state_d = ST_LOAD;
                    end else if (req_size_i == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                word_d  = ram_rd_data_i;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                word_d  = ram_rd_data_i;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            word_q  <= word_d;
        end
    end

    // Word stores also go through the merge path: for SZ_WORD it passes wdata unchanged.
    assign ram_rd_en_o   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign ram_rd_addr_o = ram_rd_en_o ? req_q.addr : '0;
    assign ram_wr_en_o   = (state_q == ST_WRITE);
    assign ram_wr_addr_o = ram_wr_en_o ? req_q.addr : '0;
    assign ram_wr_data_o = ram_wr_en_o ? merge_val : '0;

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_err_o   = rsp_valid_o & req_q.err;
    assign rsp_rdata_o = (rsp_valid_o && !req_q.err && !req_q.we) ? load_val : '0;

    a_rd_wr_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(ram_rd_en_o && ram_wr_en_o));
    a_fault_no_mem: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q == ST_RESP && req_q.err) |-> $past(state_q == ST_IDLE));

endmodule
